dff_rs_sync_async: RTL and testbench



---
 rtl/dff_rs_sync_async.sv | 58 +++++
 tb/tb_dff_rs_sync_async.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dff_rs_sync_async.sv
// Register cell with two WIDTH-bit copies of d: q_sync takes preset on the clock edge, q_async takes it immediately.
// Optional macro DFF_RS_QN_EN adds complemented outputs q_sync_n and q_async_n.
module dff_rs_sync_async #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_sync,
  output logic [WIDTH-1:0] q_async
`ifdef DFF_RS_QN_EN
  ,
  output logic [WIDTH-1:0] q_sync_n,
  output logic [WIDTH-1:0] q_async_n
`endif
);

  logic [WIDTH-1:0] q_sync_reg;
  logic [WIDTH-1:0] q_sync_next;
  logic [WIDTH-1:0] q_async_reg;

  // The clocked preset is folded into the D input so set_n only acts at an edge.
  always_comb begin
    q_sync_next = d;
    if (!set_n) begin
      q_sync_next = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_sync_reg <= '0;
    end else begin
      q_sync_reg <= q_sync_next;
    end
  end

  // Reset is tested first so it still wins when set_n falls while reset_n is low.
  always_ff @(posedge clk or negedge reset_n or negedge set_n) begin
    if (!reset_n) begin
      q_async_reg <= '0;
    end else if (!set_n) begin
      q_async_reg <= '1;
    end else begin
      q_async_reg <= d;
    end
  end

  assign q_sync  = q_sync_reg;
  assign q_async = q_async_reg;

`ifdef DFF_RS_QN_EN
  assign q_sync_n  = ~q_sync_reg;
  assign q_async_n = ~q_async_reg;
`endif

endmodule

// File: tb/tb_dff_rs_sync_async.sv
// Directed bench for dff_rs_sync_async: a WIDTH=1 instance and a WIDTH=8 instance share clock and controls.
// Covers reset hold, data load, between-edge preset pulses, clocked preset and reset overriding preset.
module tb_dff_rs_sync_async;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       set_n;
  logic       d;
  logic [7:0] d8;
  logic       q_sync, q_async;
  logic [7:0] q8_sync, q8_async;
`ifdef DFF_RS_QN_EN
  logic       q_sync_n, q_async_n;
  logic [7:0] q8_sync_n, q8_async_n;
`endif

  int total = 0;
  int bad   = 0;

  always #15 clk = ~clk;

  dff_rs_sync_async #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_n     (set_n),
    .d         (d),
    .q_sync    (q_sync),
    .q_async   (q_async)
`ifdef DFF_RS_QN_EN
    ,
    .q_sync_n  (q_sync_n),
    .q_async_n (q_async_n)
`endif
  );

  dff_rs_sync_async #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_n     (set_n),
    .d         (d8),
    .q_sync    (q8_sync),
    .q_async   (q8_async)
`ifdef DFF_RS_QN_EN
    ,
    .q_sync_n  (q8_sync_n),
    .q_async_n (q8_async_n)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_s, input logic e_a,
                           input logic [7:0] e_s8, input logic [7:0] e_a8);
    chk({tag, ".q_sync"},   {7'b0, q_sync},  {7'b0, e_s});
    chk({tag, ".q_async"},  {7'b0, q_async}, {7'b0, e_a});
    chk({tag, ".q8_sync"},  q8_sync,         e_s8);
    chk({tag, ".q8_async"}, q8_async,        e_a8);
`ifdef DFF_RS_QN_EN
    chk({tag, ".q_sync_n"},   {7'b0, q_sync_n},  {7'b0, ~e_s});
    chk({tag, ".q_async_n"},  {7'b0, q_async_n}, {7'b0, ~e_a});
    chk({tag, ".q8_sync_n"},  q8_sync_n,         ~e_s8);
    chk({tag, ".q8_async_n"}, q8_async_n,        ~e_a8);
`endif
    $display("step %-14s t=%0t q_sync=%b q_async=%b q8_sync=%h q8_async=%h", tag, $time,
             q_sync, q_async, q8_sync, q8_async);
  endtask

  initial begin
    reset_n = 1'b0;
    set_n   = 1'b0;
    d       = 1'b1;
    d8      = 8'hA5;

    // Reset holds everything at zero across edges even with preset and data active.
    repeat (3) begin
      @(posedge clk); #1;
      check_all("rst_hold", 1'b0, 1'b0, 8'h00, 8'h00);
    end

    @(negedge clk);
    reset_n = 1'b1; set_n = 1'b1; d = 1'b1; d8 = 8'h3C;
    #1 check_all("rel_hold", 1'b0, 1'b0, 8'h00, 8'h00);

    @(posedge clk); #1 check_all("load1", 1'b1, 1'b1, 8'h3C, 8'h3C);

    @(negedge clk);
    d = 1'b0; d8 = 8'hC3;
    @(posedge clk); #1 check_all("load0", 1'b0, 1'b0, 8'hC3, 8'hC3);

    @(negedge clk);
    d8 = 8'h00;
    @(posedge clk); #1 check_all("load00", 1'b0, 1'b0, 8'h00, 8'h00);

    // 5 ns preset pulse wholly between edges.
    #9 set_n = 1'b0;
    #1 check_all("pulse_lo", 1'b0, 1'b1, 8'h00, 8'hFF);
    #4 set_n = 1'b1;
    #1 check_all("pulse_rel", 1'b0, 1'b1, 8'h00, 8'hFF);
    @(posedge clk); #1 check_all("pulse_edge", 1'b0, 1'b0, 8'h00, 8'h00);

    // Preset held across an edge.
    @(negedge clk);
    set_n = 1'b0; d8 = 8'h5A;
    #1 check_all("set_lo", 1'b0, 1'b1, 8'h00, 8'hFF);
    @(posedge clk); #1 check_all("set_edge", 1'b1, 1'b1, 8'hFF, 8'hFF);
    @(negedge clk);
    set_n = 1'b1;
    #1 check_all("set_rel", 1'b1, 1'b1, 8'hFF, 8'hFF);
    @(posedge clk); #1 check_all("set_load", 1'b0, 1'b0, 8'h5A, 8'h5A);

    @(negedge clk);
    d = 1'b1; d8 = 8'h96;
    @(posedge clk); #1 check_all("ones", 1'b1, 1'b1, 8'h96, 8'h96);

    // Reset 5 ns before an edge, then preset while reset is held.
    #24 reset_n = 1'b0;
    #1 check_all("rst_mid", 1'b0, 1'b0, 8'h00, 8'h00);
    #1 set_n = 1'b0;
    #1 check_all("rst_set", 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1 check_all("rst_edge", 1'b0, 1'b0, 8'h00, 8'h00);
    #4 set_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_all("rel2", 1'b0, 1'b0, 8'h00, 8'h00);
    #4 set_n = 1'b0;
    #1 check_all("set_after_rst", 1'b0, 1'b1, 8'h00, 8'hFF);
    @(posedge clk); #1 check_all("set_edge2", 1'b1, 1'b1, 8'hFF, 8'hFF);
    @(negedge clk);
    set_n = 1'b1; d = 1'b0; d8 = 8'h81;
    @(posedge clk); #1 check_all("final_load", 1'b0, 1'b0, 8'h81, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
